// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath.
//   state_t : controller state encoding (ST_IDLE .. ST_DONE)
//   clog2   : counter width helper, never returns less than 1
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_MUL    = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Bits needed to hold values 0 .. v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/mod_mul_seq.sv
// Sequential shift-add modular multiplier: P = A*B mod N, MSB-first over B.
// The first step is taken on the go edge straight from the input ports, so P
// is final after n edges and rdy is high during the n-th cycle after go.
// Precondition: A < N, N != 0. B may be any value.
// Ports:
//   clk, rst      clock, async active-high reset
//   go            start pulse; A, B, N sampled on this edge
//   A, B, N       operands / modulus (n bits)
//   P             product register (n bits), held until next go
//   rdy           one-cycle pulse, P valid while high
module mod_mul_seq
  import rsa_pkg::*;
#(
  parameter int unsigned n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [n-1:0] N,
  output logic [n-1:0] P,
  output logic         rdy
);

  localparam int unsigned CW = clog2(n);

  logic [n-1:0]  acc;
  logic [n-1:0]  a_q;
  logic [n-1:0]  b_q;
  logic [n-1:0]  n_q;
  logic [CW-1:0] cnt;

  // One Horner step; n+1 bits hold 2*acc and acc+a without overflow.
  function automatic logic [n-1:0] step(input logic [n-1:0] acc_in,
                                        input logic         bit_in,
                                        input logic [n-1:0] a,
                                        input logic [n-1:0] m);
    logic [n:0] t;
    logic [n:0] mm;
    mm = {1'b0, m};
    t  = {acc_in, 1'b0};
    if (t >= mm) t = t - mm;
    if (bit_in)  t = t + {1'b0, a};
    if (t >= mm) t = t - mm;
    return t[n-1:0];
  endfunction

  // Step sequencer: go loads operands and performs step 1, then n-1 more.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      n_q <= '0;
      cnt <= '0;
      rdy <= 1'b0;
    end else if (go) begin
      acc <= step('0, B[n-1], A, N);
      a_q <= A;
      b_q <= {B[n-2:0], 1'b0};
      n_q <= N;
      cnt <= CW'(n - 1);
      rdy <= 1'b0;
    end else if (cnt != '0) begin
      acc <= step(acc, b_q[n-1], a_q, n_q);
      b_q <= b_q << 1;
      cnt <= cnt - CW'(1);
      rdy <= (cnt == CW'(1));
    end else begin
      rdy <= 1'b0;
    end
  end

  assign P = acc;

endmodule

// File: rtl/mod_exp_seq.sv
// Sequential modular exponentiation RESULT = BASE^KEY mod N using
// right-to-left square-and-multiply with two parallel mod_mul_seq units.
// mul_b first reduces BASE mod N, then squares b; mul_r forms r*b.
// Build option: MODEXP_EARLY_EXIT_EN stops once the remaining key bits are 0.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           request, accepted in IDLE only
//   KEY, BASE, N    operands (n bits), sampled on accept
//   busy            high while computing
//   done            one-cycle pulse when RESULT/err are updated
//   err             N was 0; held until next accept
//   RESULT          BASE^KEY mod N; held until the next done
module mod_exp_seq
  import rsa_pkg::*;
#(
  parameter int unsigned n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] KEY,
  input  logic [n-1:0] BASE,
  input  logic [n-1:0] N,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [n-1:0] RESULT
);

  localparam int unsigned CW = clog2(n);

  state_t        state;
  logic [n-1:0]  key_q;
  logic [n-1:0]  n_q;
  logic [n-1:0]  r_q;
  logic [n-1:0]  b_q;
  logic [CW-1:0] bit_cnt;

  logic          go_b, go_r, rdy_b, rdy_r;
  logic [n-1:0]  p_b, p_r;
  logic [n-1:0]  mb_a, mb_b, mr_a, mr_b, m_n;
  logic          last_bit, skip_all;

  // Termination conditions for the bit loop.
  always_comb begin
    last_bit = (bit_cnt == CW'(n - 1));
    skip_all = 1'b0;
`ifdef MODEXP_EARLY_EXIT_EN
    if ((key_q >> 1) == '0) last_bit = 1'b1;
    skip_all = (key_q == '0);
`endif
  end

  // Operand routing and multiplier launch. Launches coincide with the edge
  // that commits b, so the freshly computed p_b is forwarded directly.
  always_comb begin
    mb_a = b_q;
    mb_b = b_q;
    mr_a = r_q;
    mr_b = b_q;
    m_n  = n_q;
    go_b = 1'b0;
    go_r = 1'b0;
    case (state)
      ST_IDLE: begin
        mb_a = (N == n'(1)) ? '0 : n'(1);
        mb_b = BASE;
        m_n  = N;
        go_b = start && (N != '0);
      end
      ST_REDUCE: begin
        mb_a = p_b;
        mb_b = p_b;
        mr_b = p_b;
        if (rdy_b && !skip_all) begin
          go_b = 1'b1;
          go_r = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (!last_bit) begin
          go_b = 1'b1;
          go_r = 1'b1;
        end
      end
      default: ;
    endcase
  end

  mod_mul_seq #(.n(n)) u_mul_b (
    .clk(clk), .rst(rst), .go(go_b),
    .A(mb_a), .B(mb_b), .N(m_n), .P(p_b), .rdy(rdy_b)
  );

  mod_mul_seq #(.n(n)) u_mul_r (
    .clk(clk), .rst(rst), .go(go_r),
    .A(mr_a), .B(mr_b), .N(m_n), .P(p_r), .rdy(rdy_r)
  );

  // Controller with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      key_q   <= '0;
      n_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      RESULT  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_q   <= KEY;
            n_q     <= N;
            r_q     <= (N == n'(1)) ? '0 : n'(1);
            b_q     <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
            if (N == '0) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              RESULT <= '0;
            end else begin
              state <= ST_REDUCE;
              busy  <= 1'b1;
            end
          end
        end
        ST_REDUCE: begin
          if (rdy_b) begin
            b_q <= p_b;
            if (skip_all) begin
              state  <= ST_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              RESULT <= r_q;
            end else begin
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (rdy_b && rdy_r) begin
            b_q <= p_b;
            if (key_q[0]) r_q <= p_r;
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          key_q   <= key_q >> 1;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            RESULT <= r_q;
          end else begin
            state <= ST_MUL;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_seq.sv
// Directed bench for mod_exp_seq at n=6: vector table plus handshake,
// back-to-back, mid-run start and mid-run reset sequences.
module tb_mod_exp_seq;

  localparam int unsigned NW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] key, base, nmod, result;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int b;
    int k;
    int m;
    int r;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  mod_exp_seq #(.n(NW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .KEY(key), .BASE(base), .N(nmod),
    .busy(busy), .done(done), .err(err), .RESULT(result)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_busy(input int kv);
    int k;
    k = 0;
    for (int i = 0; i < NW; i++) if (kv[i]) k = i + 1;
`ifdef MODEXP_EARLY_EXIT_EN
    return NW + k * (NW + 1);
`else
    return (k >= 0) ? NW * (NW + 2) : 0;
`endif
  endfunction

  // Issue one request and wait for done; counts busy cycles at negedges.
  task automatic run(input int ib, input int ik, input int im,
                     output int res, output int e, output int bcnt, output int to);
    @(negedge clk);
    base  = NW'(ib);
    key   = NW'(ik);
    nmod  = NW'(im);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcnt  = 0;
    to    = 1;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin
        to = 0;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
    res = int'(result);
    e   = int'(err);
  endtask

  initial begin
    int res, e, bcnt, to;
    int ndone, last_t, gap_ok, stable, extra;

    tbl[0]  = '{3, 15, 2, 1};
    tbl[1]  = '{50, 6, 35, 15};
    tbl[2]  = '{4, 13, 33, 31};
    tbl[3]  = '{5, 0, 7, 1};
    tbl[4]  = '{5, 0, 1, 0};
    tbl[5]  = '{63, 63, 63, 0};
    tbl[6]  = '{63, 1, 61, 2};
    tbl[7]  = '{2, 10, 63, 16};
    tbl[8]  = '{10, 5, 13, 4};
    tbl[9]  = '{3, 32, 7, 2};
    tbl[10] = '{0, 0, 5, 1};
    tbl[11] = '{7, 2, 50, 49};

    rst = 1'b1; start = 1'b0; key = '0; base = '0; nmod = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_result", int'(result), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].b, tbl[i].k, tbl[i].m, res, e, bcnt, to);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_result", i), res, tbl[i].r);
      check($sformatf("v%0d_err", i), e, 0);
      check($sformatf("v%0d_busy_cycles", i), bcnt, exp_busy(tbl[i].k));
      check($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
    end

    // N=0: immediate done with err, then cleared by a valid request.
    run(9, 5, 0, res, e, bcnt, to);
    check("n0_timeout", to, 0);
    check("n0_err", e, 1);
    check("n0_result", res, 0);
    check("n0_busy_cycles", bcnt, 0);
    run(4, 13, 33, res, e, bcnt, to);
    check("n0_next_err", e, 0);
    check("n0_next_result", res, 31);

    // start held high: back-to-back runs, fixed spacing, RESULT stable.
    @(negedge clk);
    base = 6'd4; key = 6'd13; nmod = 6'd33; start = 1'b1;
    ndone = 0; last_t = 0; gap_ok = 1; stable = 1;
    for (int c = 0; c < 400 && ndone < 3; c++) begin
      @(negedge clk);
      if (result != 6'd31) stable = 0;
      if (done) begin
        if (ndone > 0 && (c - last_t) != exp_busy(13) + 2) gap_ok = 0;
        last_t = c;
        ndone++;
      end
    end
    start = 1'b0;
    check("hold_dones", ndone, 3);
    check("hold_gap", gap_ok, 1);
    check("hold_stable", stable, 1);
    @(negedge clk);
    @(negedge clk);
    check("hold_idle_after", int'(busy), 0);

    // start pulsed mid-computation must be ignored.
    @(negedge clk);
    base = 6'd10; key = 6'd5; nmod = 6'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcnt = 0; to = 1;
    for (int c = 0; c < 1000; c++) begin
      if (done) begin
        to = 0;
        break;
      end
      if (busy) bcnt++;
      if (bcnt == 10) begin
        start = 1'b1; base = 6'd3; key = 6'd3; nmod = 6'd5;
      end
      if (bcnt == 13) start = 1'b0;
      @(negedge clk);
    end
    check("mid_timeout", to, 0);
    check("mid_result", int'(result), 4);
    check("mid_busy_cycles", bcnt, exp_busy(5));
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    check("mid_no_extra", extra, 0);

    // Reset at busy cycle 20 aborts at once; fresh request still correct.
    @(negedge clk);
    base = 6'd63; key = 6'd63; nmod = 6'd61; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    for (int c = 0; c < 1000 && bcnt < 20; c++) begin
      if (busy) bcnt++;
      if (bcnt < 20) @(negedge clk);
    end
    check("rstmid_reached", bcnt, 20);
    rst = 1'b1;
    #1;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_done", int'(done), 0);
    check("rstmid_result", int'(result), 0);
    check("rstmid_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    run(63, 1, 61, res, e, bcnt, to);
    check("rstmid_after_timeout", to, 0);
    check("rstmid_after_result", res, 2);
    check("rstmid_after_busy", bcnt, exp_busy(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
